// File: rtl/normalize_seq.sv
// Sequential normalizer: shifts a captured operand left one bit per cycle until
// its MSB is set, reporting the shifted value and the leading-zero count.
module normalize_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic [5:0]       lz,
    output logic             zero
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] shift_reg;
    logic [4:0]       count_reg;
    logic [WIDTH-1:0] dout_reg;
    logic [5:0]       lz_reg;
    logic             zero_reg;
    logic             ready_reg;
    logic             busy_reg;
    logic             done_reg;

    // Status flags are registered alongside the state so they mirror it exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            shift_reg <= '0;
            count_reg <= '0;
            dout_reg  <= '0;
            lz_reg    <= '0;
            zero_reg  <= 1'b0;
            ready_reg <= 1'b1;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        shift_reg <= din;
                        count_reg <= '0;
                        ready_reg <= 1'b0;
                        if (din == '0) begin
                            // A zero operand never terminates shifting; report it directly.
                            state_reg <= DONE;
                            dout_reg  <= '0;
                            lz_reg    <= 6'd32;
                            zero_reg  <= 1'b1;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= SHIFT;
                            busy_reg  <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (shift_reg[WIDTH-1]) begin
                        state_reg <= DONE;
                        dout_reg  <= shift_reg;
                        lz_reg    <= {1'b0, count_reg};
                        zero_reg  <= 1'b0;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else begin
                        shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
                        count_reg <= count_reg + 5'd1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    done_reg  <= 1'b0;
                    ready_reg <= 1'b1;
                end
                default: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b1;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign ready = ready_reg;
    assign busy  = busy_reg;
    assign done  = done_reg;
    assign dout  = dout_reg;
    assign lz    = lz_reg;
    assign zero  = zero_reg;

endmodule

// File: tb/tb_normalize_seq.sv
// Randomized self-checking bench for normalize_seq against a leading-zero
// reference model, plus directed corner cases and a mid-run reset.
module tb_normalize_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] din;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] dout;
    logic [5:0]  lz;
    logic        zero;

    int n_vec;
    int n_err;

    normalize_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .din   (din),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .dout  (dout),
        .lz    (lz),
        .zero  (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: leading-zero count found by scanning from the MSB.
    function automatic int ref_lz(input logic [31:0] v);
        int n;
        n = 32;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) begin
                n = 31 - i;
                break;
            end
        end
        return n;
    endfunction

    // Called at a falling edge with the block idle; returns at the falling edge after done.
    task automatic do_op(input logic [31:0] v, input bit repulse, input string name);
        int          exp_lz;
        logic [31:0] exp_dout;
        int          exp_lat;
        int          k;
        int          busy_n;
        bit          seen;
        exp_lz   = ref_lz(v);
        exp_dout = (exp_lz == 32) ? 32'h0 : (v << exp_lz);
        exp_lat  = (v == 32'h0) ? 1 : exp_lz + 2;
        check({name, "_ready"}, {63'h0, ready}, 64'h1);
        start = 1'b1;
        din   = v;
        @(negedge clk);
        start  = 1'b0;
        din    = $urandom;
        k      = 1;
        seen   = 1'b0;
        busy_n = 0;
        while (!seen && k <= 40) begin
            if (busy) busy_n++;
            if (done) begin
                seen = 1'b1;
            end else begin
                start = repulse && (k == 3);
                din   = start ? 32'hFFFF_FFFF : $urandom;
                @(negedge clk);
                k++;
            end
        end
        start = 1'b0;
        check({name, "_latency"}, seen ? 64'(k) : 64'd999, 64'(exp_lat));
        check({name, "_busy_cycles"}, 64'(busy_n), (v == 32'h0) ? 64'd0 : 64'(exp_lz + 1));
        check({name, "_dout"}, {32'h0, dout}, {32'h0, exp_dout});
        check({name, "_lz"}, {58'h0, lz}, 64'(exp_lz));
        check({name, "_zero"}, {63'h0, zero}, {63'h0, v == 32'h0});
        @(negedge clk);
        check({name, "_done_pulse"}, {62'h0, done, ready}, 64'h1);
        check({name, "_hold"}, {26'h0, lz, dout}, {26'h0, 6'(exp_lz), exp_dout});
        $display("op %-10s din=%08h dout=%08h lz=%0d zero=%0b lat=%0d", name, v, dout, lz, zero, k);
    endtask

    initial begin
        logic [31:0] v;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b1;
        start = 1'b0;
        din   = 32'h0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", {56'h0, ready, busy, done, zero, lz == 6'd0, dout == 32'h0, 2'b00},
              {56'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00});
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_rst", {26'h0, ready, busy, done, zero, lz, dout},
              {26'h0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0});

        do_op(32'h8000_0000, 1'b0, "msb_set");
        do_op(32'h0000_0001, 1'b0, "lsb_only");
        do_op(32'h0000_0000, 1'b0, "zero_op");
        do_op(32'h0003_F00A, 1'b1, "repulse");

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 7))
                0:       v = 32'h0;
                1:       v = 32'h1 << $urandom_range(0, 31);
                default: v = $urandom >> $urandom_range(0, 31);
            endcase
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_op(v, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
        end

        do_op(32'h1234_5678, 1'b0, "pre_reset");
        // Abort an operation five cycles after acceptance.
        start = 1'b1;
        din   = 32'h0000_0100;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("midrun_busy", {63'h0, busy}, 64'h1);
        rst_n = 1'b0;
        #1;
        check("abort_clear", {26'h0, ready, busy, done, zero, lz, dout},
              {26'h0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 32'h0});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_done", {63'h0, done}, 64'h0);
        end
        rst_n = 1'b1;
        do_op(32'h4000_0000, 1'b0, "post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
